md_sched: RTL

//  Multi-cycle multiply/divide scheduler for the 5-stage pipeline, beside the E-stage ALU.

---
 rtl/md_sched_pkg.sv | 41 ++++
 rtl/md_sched_if.sv | 26 ++
 rtl/md_sched_arith.sv | 64 ++++++
 rtl/md_sched.sv | 115 +++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op codes, FSM states, op-class decode.
// Optional feature macro: MD_MADD_EN (MADD/MADDU/MSUB/MSUBU become MULT-class ops).
package md_sched_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } mdOp_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdState_e;

  // Accumulate ops only count as multiplies when the feature is built in
  function automatic logic isMulOp(input logic [MD_OP_W-1:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic isDivOp(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Handshake/data bundle between the E-stage/hazard unit and the MD scheduler.
interface md_sched_if;

  logic                              Start;
  logic [md_sched_pkg::MD_OP_W-1:0]  MDOp;
  logic [31:0]                       Data1;
  logic [31:0]                       Data2;
  logic                              RdHi;
  logic                              D_isMD;
  logic                              Busy;
  logic                              Stall_MD;
  logic [31:0]                       HI;
  logic [31:0]                       LO;
  logic [31:0]                       MD_Out;

  modport master (
    output Start, MDOp, Data1, Data2, RdHi, D_isMD,
    input  Busy, Stall_MD, HI, LO, MD_Out
  );

  modport slave (
    input  Start, MDOp, Data1, Data2, RdHi, D_isMD,
    output Busy, Stall_MD, HI, LO, MD_Out
  );

endinterface

// File: rtl/md_sched_arith.sv
// Combinational MD datapath: latched op and operands plus current HI/LO -> 64-bit {HI,LO} result.
// Accumulate ops are only built when MD_MADD_EN is defined.
module md_sched_arith
  import md_sched_pkg::*;
(
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [31:0]        a_i,
  input  logic [31:0]        b_i,
  input  logic [31:0]        hi_i,
  input  logic [31:0]        lo_i,
  output logic [63:0]        result_o,
  output logic               div0_o
);

  logic [63:0] sProd;
  logic [63:0] uProd;
  logic [31:0] uDivisor;
  logic [31:0] uQuo, uRem;
  logic [31:0] aMag, bMag, bMagSafe;
  logic [31:0] magQuo, magRem;
  logic [31:0] sQuo, sRem;

  assign sProd = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign uProd = {32'd0, a_i} * {32'd0, b_i};

  // Divisor forced non-zero so the dividers never see x/0; div0_o masks the result
  assign uDivisor = (b_i == 32'd0) ? 32'd1 : b_i;
  assign uQuo     = a_i / uDivisor;
  assign uRem     = a_i % uDivisor;

  // Signed divide on magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0
  assign aMag     = a_i[31] ? (32'd0 - a_i) : a_i;
  assign bMag     = b_i[31] ? (32'd0 - b_i) : b_i;
  assign bMagSafe = (bMag == 32'd0) ? 32'd1 : bMag;
  assign magQuo   = aMag / bMagSafe;
  assign magRem   = aMag % bMagSafe;
  assign sQuo     = (a_i[31] ^ b_i[31]) ? (32'd0 - magQuo) : magQuo;
  assign sRem     = a_i[31] ? (32'd0 - magRem) : magRem;

  always_comb begin
    result_o = {hi_i, lo_i};
    div0_o   = 1'b0;
    case (op_i)
      MD_MULT:  result_o = sProd;
      MD_MULTU: result_o = uProd;
      MD_DIV: begin
        div0_o = (b_i == 32'd0);
        if (!div0_o) result_o = {sRem, sQuo};
      end
      MD_DIVU: begin
        div0_o = (b_i == 32'd0);
        if (!div0_o) result_o = {uRem, uQuo};
      end
`ifdef MD_MADD_EN
      MD_MADD:  result_o = {hi_i, lo_i} + sProd;
      MD_MADDU: result_o = {hi_i, lo_i} + uProd;
      MD_MSUB:  result_o = {hi_i, lo_i} - sProd;
      MD_MSUBU: result_o = {hi_i, lo_i} - uProd;
`endif
      default:  result_o = {hi_i, lo_i};
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle MULT/DIV scheduler with HI/LO registers, latency counter and MD stall request.
// Optional feature macro: MD_MADD_EN (accumulate ops accepted as MULT-class).
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  md_sched_if.slave  mdIf
);

  mdState_e           stateQ, stateD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic [MD_OP_W-1:0] opQ, opD;
  logic [31:0]        aQ, aD;
  logic [31:0]        bQ, bD;
  logic [31:0]        hiQ, hiD;
  logic [31:0]        loQ, loD;

  logic [63:0]        arithResult;
  logic               arithDiv0;
  logic               startMul, startDiv;
  logic               lastCycle;

  assign startMul  = mdIf.Start && isMulOp(mdIf.MDOp);
  assign startDiv  = mdIf.Start && isDivOp(mdIf.MDOp);
  assign lastCycle = (cntQ == CNT_W'(1));

  md_sched_arith u_arith (
    .op_i     (opQ),
    .a_i      (aQ),
    .b_i      (bQ),
    .hi_i     (hiQ),
    .lo_i     (loQ),
    .result_o (arithResult),
    .div0_o   (arithDiv0)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) stateQ <= S_IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      S_IDLE: begin
        if (startMul)      stateD = S_MUL;
        else if (startDiv) stateD = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (lastCycle) stateD = S_IDLE;
      end
      default: stateD = S_IDLE;
    endcase
  end

  always_comb begin
    mdIf.Busy     = (stateQ != S_IDLE);
    mdIf.Stall_MD = mdIf.D_isMD && (mdIf.Busy || startMul || startDiv);
    mdIf.HI       = hiQ;
    mdIf.LO       = loQ;
    mdIf.MD_Out   = mdIf.RdHi ? hiQ : loQ;
  end

  // Starts, MT writes and late starts are only honoured in IDLE
  always_comb begin
    cntD = cntQ;
    opD  = opQ;
    aD   = aQ;
    bD   = bQ;
    hiD  = hiQ;
    loD  = loQ;
    if (stateQ == S_IDLE) begin
      if (startMul || startDiv) begin
        cntD = startMul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        opD  = mdIf.MDOp;
        aD   = mdIf.Data1;
        bD   = mdIf.Data2;
      end else if (mdIf.Start && (mdIf.MDOp == MD_MTHI)) begin
        hiD = mdIf.Data1;
      end else if (mdIf.Start && (mdIf.MDOp == MD_MTLO)) begin
        loD = mdIf.Data1;
      end
    end else begin
      cntD = cntQ - CNT_W'(1);
      if (lastCycle && !arithDiv0) begin
        hiD = arithResult[63:32];
        loD = arithResult[31:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cntQ <= '0;
      opQ  <= '0;
      aQ   <= '0;
      bQ   <= '0;
      hiQ  <= '0;
      loQ  <= '0;
    end else begin
      cntQ <= cntD;
      opQ  <= opD;
      aQ   <= aD;
      bQ   <= bD;
      hiQ  <= hiD;
      loQ  <= loD;
    end
  end

endmodule
